// File: rtl/hht_control.sv
// Householder-transform sequencer/datapath.
// For each full N-word column a of a column-major matrix region it forms
// p = v.a (DOT phase, N cycles), then streams y[i] = a[i] - 2*p*v[i]
// (UPD phase, N cycles) with the destination address of each word.
// The vector v is fetched once during column 0 and kept in a register file.
// Run enable RD is level-sensitive: a cycle with RD=0 in DOT/UPD holds
// every counter, the accumulator and both addresses, and issues no y_valid.
// Read data on dataIn1/dataIn2 is combinational from addr1/addr2.
module hht_control #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [W-1:0] v_values_base,
  input  logic [W-1:0] wdata_col_base,
  output logic [W-1:0] addr1,
  output logic [W-1:0] addr2,
  input  logic [W-1:0] dataIn1,
  input  logic [W-1:0] dataIn2,
  input  logic [W-1:0] csize,
  input  logic         RD,
  output logic [W-1:0] y_out,
  output logic         y_valid,
  output logic [W-1:0] y_addr,
  output logic         done,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOT  = 2'd1,
    UPD  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [W-1:0]  N_W      = W'(N);
  localparam logic [W-1:0]  ONE_W    = W'(1);

  state_t        state;
  logic [W-1:0]  ncols;      // columns to process, sampled when leaving IDLE
  logic [W-1:0]  col;
  logic [W-1:0]  col_base;   // address of row 0 of the current column
  logic [RW-1:0] row;
  logic [W-1:0]  acc;
  logic [W-1:0]  p;
  logic [W-1:0]  vreg [N];

  logic [W-1:0]  csize_cols;
  logic [W-1:0]  v_cur;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  upd_term;

  assign dbg_state = state;

  // Datapath arithmetic: column count, dot-product step and update term
  always_comb begin
    csize_cols = csize / N_W;
    // In column 0 the vector word arrives this cycle; afterwards use the copy
    v_cur      = (col == '0) ? dataIn2 : vreg[row];
    acc_next   = acc + (v_cur * dataIn1);
    upd_term   = (p * vreg[row]) << 1;
  end

  // Sequencer FSM with registered addresses and outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      addr1    <= '0;
      addr2    <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      y_addr   <= '0;
      done     <= 1'b0;
      ncols    <= '0;
      col      <= '0;
      col_base <= '0;
      row      <= '0;
      acc      <= '0;
      p        <= '0;
      for (int i = 0; i < N; i++) begin
        vreg[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (RD) begin
            ncols <= csize_cols;
            col   <= '0;
            row   <= '0;
            acc   <= '0;
            if (csize_cols != '0) begin
              addr1    <= wdata_col_base;
              addr2    <= v_values_base;
              col_base <= wdata_col_base;
              state    <= DOT;
            end else begin
              state <= FIN;
            end
          end
        end
        DOT: begin
          if (RD) begin
            if (col == '0) begin
              vreg[row] <= dataIn2;
            end
            acc <= acc_next;
            if (row == ROW_LAST) begin
              p     <= acc_next;
              row   <= '0;
              addr1 <= col_base;
              state <= UPD;
            end else begin
              row   <= row + ROW_ONE;
              addr1 <= addr1 + ONE_W;
              if (col == '0) begin
                addr2 <= addr2 + ONE_W;
              end
            end
          end
        end
        UPD: begin
          if (RD) begin
            y_out   <= dataIn1 - upd_term;
            y_addr  <= addr1;
            y_valid <= 1'b1;
            if (row == ROW_LAST) begin
              row <= '0;
              col <= col + ONE_W;
              if ((col + ONE_W) < ncols) begin
                acc      <= '0;
                col_base <= col_base + N_W;
                addr1    <= addr1 + ONE_W;
                state    <= DOT;
              end else begin
                state <= FIN;
              end
            end else begin
              row   <= row + ROW_ONE;
              addr1 <= addr1 + ONE_W;
            end
          end
        end
        FIN: begin
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hht_control.sv
// Directed testbench for hht_control with word-addressed memory models.
module tb_hht_control;

  localparam int N   = 32;
  localparam int W   = 32;
  localparam int MEM = 1024;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DOT  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         RD  = 1'b0;
  logic [W-1:0] v_values_base  = '0;
  logic [W-1:0] wdata_col_base = '0;
  logic [W-1:0] csize          = '0;
  logic [W-1:0] addr1, addr2, dataIn1, dataIn2, y_out, y_addr;
  logic         y_valid, done;
  logic [1:0]   dbg_state;

  logic [W-1:0] mat_mem [MEM];
  logic [W-1:0] vec_mem [MEM];

  assign dataIn1 = (addr1 < MEM) ? mat_mem[addr1[9:0]] : 32'hDEAD_BEEF;
  assign dataIn2 = (addr2 < MEM) ? vec_mem[addr2[9:0]] : 32'hDEAD_BEEF;

  hht_control #(.N(N), .W(W)) dut (
    .Clk(Clk), .Rst(Rst),
    .v_values_base(v_values_base), .wdata_col_base(wdata_col_base),
    .addr1(addr1), .addr2(addr2), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .csize(csize), .RD(RD),
    .y_out(y_out), .y_valid(y_valid), .y_addr(y_addr), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock
  always #5 Clk = ~Clk;

  int checks = 0;
  int passed = 0;

  // Results gathered by run_collect
  logic [W-1:0] got_y    [512];
  logic [W-1:0] got_addr [512];
  int n_y, cyc, done_cyc, last_y_cyc, addr2_bad;
  logic [W-1:0] max_addr1;
  int full_cyc;

  // Scoreboard
  logic [W-1:0] exp_q [$];
  int data_bad, addr_bad, first_bad;
  logic [W-1:0] bad_got, bad_exp;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RD  = 1'b0;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic clear_mems();
    for (int i = 0; i < MEM; i++) begin
      mat_mem[i] = '0;
      vec_mem[i] = '0;
    end
  endtask

  // Reference model: pushes expected y words for ncols columns
  task automatic build_expected(input logic [W-1:0] b1, input logic [W-1:0] b2, input int ncols);
    logic [W-1:0] pp, a, v;
    exp_q.delete();
    for (int c = 0; c < ncols; c++) begin
      pp = '0;
      for (int i = 0; i < N; i++) begin
        a  = mat_mem[b1 + W'(c * N + i)];
        v  = vec_mem[b2 + W'(i)];
        pp = pp + a * v;
      end
      for (int i = 0; i < N; i++) begin
        a = mat_mem[b1 + W'(c * N + i)];
        v = vec_mem[b2 + W'(i)];
        exp_q.push_back(a - 32'(2) * pp * v);
      end
    end
  endtask

  // Run with RD=1 until done or budget; optional RD drop in column 1 DOT
  task automatic run_collect(input int stall_len, input int budget);
    int  stall_left;
    bit  stall_used, seen_upd;
    n_y = 0; cyc = 0; done_cyc = -1; last_y_cyc = -1; addr2_bad = 0;
    max_addr1 = '0; stall_left = 0; stall_used = 0; seen_upd = 0;
    RD = 1'b1;
    while (done_cyc < 0 && cyc < budget) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      if (y_valid) begin
        if (n_y < 512) begin
          got_y[n_y]    = y_out;
          got_addr[n_y] = y_addr;
        end
        n_y++;
        last_y_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      if (dbg_state != S_IDLE && addr1 > max_addr1) max_addr1 = addr1;
      if (dbg_state == S_UPD) seen_upd = 1;
      if (!seen_upd && dbg_state == S_DOT) begin
        if (addr2 !== v_values_base + W'(cyc - 1)) addr2_bad++;
      end else if (seen_upd) begin
        if (addr2 !== v_values_base + W'(N - 1)) addr2_bad++;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) RD = 1'b1;
      end else if (stall_len > 0 && !stall_used && dbg_state == S_DOT &&
                   addr1 == wdata_col_base + W'(N + 10)) begin
        RD = 1'b0;
        stall_left = stall_len;
        stall_used = 1;
      end
    end
    RD = 1'b0;
  endtask

  // Compare collected words against exp_q and contiguous addresses
  task automatic score();
    logic [W-1:0] e;
    data_bad = 0; addr_bad = 0; first_bad = -1; bad_got = '0; bad_exp = '0;
    for (int k = 0; k < n_y && k < 512; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
      if (got_y[k] !== e) begin
        if (first_bad < 0) begin first_bad = k; bad_got = got_y[k]; bad_exp = e; end
        data_bad++;
      end
      if (got_addr[k] !== wdata_col_base + W'(k)) addr_bad++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (dbg_state !== S_IDLE) $display("FAIL reset_state got %0d want 0", dbg_state); else passed++;
    checks++; if ({addr1, addr2, y_out, y_addr} !== '0) $display("FAIL reset_addr_data got %h %h %h %h want 0", addr1, addr2, y_out, y_addr); else passed++;
    checks++; if ({y_valid, done} !== 2'b00) $display("FAIL reset_flags got %b%b want 00", y_valid, done); else passed++;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (addr1 !== '0 || addr2 !== '0 || dbg_state !== S_IDLE) $display("FAIL idle_hold got a1=%0d a2=%0d st=%0d want 0 0 0", addr1, addr2, dbg_state); else passed++;
  endtask

  task automatic test_single_column();
    clear_mems();
    for (int i = 0; i < N; i++) begin
      mat_mem[340 + i] = W'(i);
      vec_mem[2 + i]   = 32'd1;
    end
    wdata_col_base = 340; v_values_base = 2; csize = 32;
    build_expected(340, 2, 1);
    do_reset();
    run_collect(0, 200);
    score();
    checks++; if (n_y !== 32) $display("FAIL single_count got %0d want 32", n_y); else passed++;
    checks++; if (got_y[0] !== 32'hFFFF_FC20) $display("FAIL single_y0 got %h want FFFFFC20", got_y[0]); else passed++;
    checks++; if (got_y[31] !== 32'hFFFF_FC3F) $display("FAIL single_y31 got %h want FFFFFC3F", got_y[31]); else passed++;
    checks++; if (data_bad !== 0) $display("FAIL single_data got %0d bad (idx %0d got %h want %h) want 0", data_bad, first_bad, bad_got, bad_exp); else passed++;
    checks++; if (addr_bad !== 0 || got_addr[31] !== 371) $display("FAIL single_addr got %0d bad last=%0d want 0 bad last=371", addr_bad, got_addr[31]); else passed++;
    checks++; if (done_cyc - last_y_cyc !== 1) $display("FAIL single_done_lag got %0d want 1", done_cyc - last_y_cyc); else passed++;
    checks++; if (done_cyc !== 66) $display("FAIL single_duration got %0d want 66", done_cyc); else passed++;
  endtask

  task automatic fill_full_pattern();
    clear_mems();
    for (int a = 0; a < MEM; a++) mat_mem[a] = W'(a) * 32'd7 + 32'h1234_0000;
    for (int i = 0; i < N; i++) vec_mem[2 + i] = W'(i) * 32'd3 + 32'd1;
    wdata_col_base = 340; v_values_base = 2; csize = 410;
  endtask

  task automatic test_full_run();
    fill_full_pattern();
    build_expected(340, 2, 12);
    do_reset();
    run_collect(0, 2000);
    score();
    full_cyc = done_cyc;
    checks++; if (done_cyc < 0) $display("FAIL full_timeout got no done want done"); else passed++;
    checks++; if (n_y !== 384) $display("FAIL full_count got %0d want 384", n_y); else passed++;
    checks++; if (data_bad !== 0) $display("FAIL full_data got %0d bad (idx %0d got %h want %h) want 0", data_bad, first_bad, bad_got, bad_exp); else passed++;
    checks++; if (addr_bad !== 0) $display("FAIL full_addr got %0d bad want 0", addr_bad); else passed++;
    checks++; if (max_addr1 > 723) $display("FAIL full_max_addr1 got %0d want <=723", max_addr1); else passed++;
    checks++; if (addr2_bad !== 0) $display("FAIL full_addr2 got %0d bad cycles want 0", addr2_bad); else passed++;
    checks++; if (done_cyc !== 770) $display("FAIL full_duration got %0d want 770", done_cyc); else passed++;
  endtask

  task automatic test_zero_vector();
    int bad;
    clear_mems();
    for (int a = 0; a < MEM; a++) mat_mem[a] = W'(a) * 32'h0001_0003 + 32'h8000_0005;
    wdata_col_base = 340; v_values_base = 2; csize = 64;
    do_reset();
    run_collect(0, 400);
    bad = 0;
    for (int k = 0; k < n_y && k < 512; k++) if (got_y[k] !== mat_mem[340 + k]) bad++;
    checks++; if (n_y !== 64) $display("FAIL zero_count got %0d want 64", n_y); else passed++;
    checks++; if (bad !== 0) $display("FAIL zero_passthru got %0d bad want 0", bad); else passed++;
  endtask

  task automatic test_stall();
    fill_full_pattern();
    build_expected(340, 2, 12);
    do_reset();
    run_collect(5, 2000);
    score();
    checks++; if (n_y !== 384) $display("FAIL stall_count got %0d want 384", n_y); else passed++;
    checks++; if (data_bad !== 0 || addr_bad !== 0) $display("FAIL stall_data got %0d/%0d bad want 0/0", data_bad, addr_bad); else passed++;
    checks++; if (done_cyc !== full_cyc + 5) $display("FAIL stall_duration got %0d want %0d", done_cyc, full_cyc + 5); else passed++;
  endtask

  task automatic test_short();
    wdata_col_base = 340; v_values_base = 2; csize = 20;
    do_reset();
    run_collect(0, 2);
    checks++; if (done_cyc < 0 || done_cyc > 2) $display("FAIL short_done got cycle %0d want 1..2", done_cyc); else passed++;
    checks++; if (n_y !== 0) $display("FAIL short_no_y got %0d want 0", n_y); else passed++;
  endtask

  task automatic test_abort_upd();
    int seen, guard;
    fill_full_pattern();
    do_reset();
    RD = 1'b1; seen = 0; guard = 0;
    while (seen < 3 && guard < 200) begin
      @(posedge Clk); @(negedge Clk);
      guard++;
      if (y_valid) seen++;
    end
    checks++; if (seen !== 3) $display("FAIL abort_reach_upd got %0d pulses want 3", seen); else passed++;
    Rst = 1'b1;
    @(posedge Clk); #1;
    checks++; if (dbg_state !== S_IDLE || y_valid !== 1'b0 || done !== 1'b0 || addr1 !== '0) $display("FAIL abort_state got st=%0d v=%b d=%b a1=%0d want 0 0 0 0", dbg_state, y_valid, done, addr1); else passed++;
    @(negedge Clk);
    Rst = 1'b0; RD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_column();
    test_full_run();
    test_zero_vector();
    test_stall();
    test_short();
    test_abort_upd();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
